// File: rtl/region_pantalla.sv
// Pixel colour stage of the VGA output path.
// Classifies the current beam position as blanking, image window or
// background, selects a 3-bit colour code accordingly, and expands each
// code bit to a full 8-bit channel. Outputs are registered (1-clock latency).
module region_pantalla #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned REGION_X0 = 0,
    parameter int unsigned REGION_Y0 = 0,
    parameter int unsigned REGION_W  = 256,
    parameter int unsigned REGION_H  = 256,
    parameter logic [2:0]  BG_COLOR  = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] readValueMemory,
    input  logic [9:0] posicionX,
    input  logic [9:0] posicionY,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam logic [10:0] H_VIS_L = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_L = 11'(V_VISIBLE);
    localparam logic [10:0] X0_L    = 11'(REGION_X0);
    localparam logic [10:0] Y0_L    = 11'(REGION_Y0);
    localparam logic [10:0] W_L     = 11'(REGION_W);
    localparam logic [10:0] H_L     = 11'(REGION_H);

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] x_off;
    logic [10:0] y_off;
    logic        blank;
    logic        in_window;
    logic [2:0]  code_d;
    logic [7:0]  red_d,   red_q;
    logic [7:0]  green_d, green_q;
    logic [7:0]  blue_d,  blue_q;

    // Classify the position and pick the colour code (blanking > window > background).
    // Window test uses an 11-bit offset: a position left of/above the window wraps
    // to >= 1025, so a single "offset < size" compare covers both bounds.
    always_comb begin
        x_ext     = {1'b0, posicionX};
        y_ext     = {1'b0, posicionY};
        x_off     = x_ext - X0_L;
        y_off     = y_ext - Y0_L;
        blank     = (x_ext >= H_VIS_L) || (y_ext >= V_VIS_L);
        in_window = (x_off < W_L) && (y_off < H_L);
        if (blank) begin
            code_d = 3'b000;
        end else if (in_window) begin
            code_d = readValueMemory;
        end else begin
            code_d = BG_COLOR;
        end
        red_d   = {8{code_d[2]}};
        green_d = {8{code_d[1]}};
        blue_d  = {8{code_d[0]}};
    end

    // Output registers: cleared asynchronously, loaded every rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_region_pantalla.sv
// Self-checking bench for region_pantalla: table-driven vectors against the
// default-parameter instance, plus hand sequences for reset, latency and a
// second instance with a non-black background colour.
module tb_region_pantalla;

    logic       clock;
    logic       reset;
    logic [2:0] readValueMemory;
    logic [9:0] posicionX;
    logic [9:0] posicionY;
    logic [7:0] red,  green,  blue;
    logic [7:0] red2, green2, blue2;

    int n_cmp;
    int n_bad;

    region_pantalla dut (
        .clock           (clock),
        .reset           (reset),
        .readValueMemory (readValueMemory),
        .posicionX       (posicionX),
        .posicionY       (posicionY),
        .red             (red),
        .green           (green),
        .blue            (blue)
    );

    region_pantalla #(.BG_COLOR(3'b001)) dut_bg (
        .clock           (clock),
        .reset           (reset),
        .readValueMemory (readValueMemory),
        .posicionX       (posicionX),
        .posicionY       (posicionY),
        .red             (red2),
        .green           (green2),
        .blue            (blue2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  code;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got RGB=%h required RGB=%h", name, got, exp);
        end
    endtask

    // Present inputs just after a rising edge, then sample 1 time unit after the next one.
    task automatic step(input logic [2:0] code, input logic [9:0] x, input logic [9:0] y);
        readValueMemory = code;
        posicionX       = x;
        posicionY       = y;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"sweep_000", 3'b000, 10'd0,    10'd0,    24'h000000};
        vecs[1]  = '{"sweep_001", 3'b001, 10'd1,    10'd0,    24'h0000FF};
        vecs[2]  = '{"sweep_010", 3'b010, 10'd2,    10'd0,    24'h00FF00};
        vecs[3]  = '{"sweep_100", 3'b100, 10'd3,    10'd0,    24'hFF0000};
        vecs[4]  = '{"sweep_011", 3'b011, 10'd4,    10'd0,    24'h00FFFF};
        vecs[5]  = '{"sweep_101", 3'b101, 10'd5,    10'd0,    24'hFF00FF};
        vecs[6]  = '{"sweep_110", 3'b110, 10'd6,    10'd0,    24'hFFFF00};
        vecs[7]  = '{"sweep_111", 3'b111, 10'd7,    10'd0,    24'hFFFFFF};
        vecs[8]  = '{"win_x255",  3'b100, 10'd255,  10'd0,    24'hFF0000};
        vecs[9]  = '{"win_x256",  3'b100, 10'd256,  10'd0,    24'h000000};
        vecs[10] = '{"win_y255",  3'b100, 10'd0,    10'd255,  24'hFF0000};
        vecs[11] = '{"win_y256",  3'b100, 10'd0,    10'd256,  24'h000000};
        vecs[12] = '{"win_corner",3'b011, 10'd255,  10'd255,  24'h00FFFF};
        vecs[13] = '{"vis_edge",  3'b111, 10'd639,  10'd479,  24'h000000};
        vecs[14] = '{"blank_x",   3'b111, 10'd640,  10'd10,   24'h000000};
        vecs[15] = '{"blank_y",   3'b111, 10'd10,   10'd480,  24'h000000};
        vecs[16] = '{"blank_max", 3'b111, 10'd1023, 10'd1023, 24'h000000};
        vecs[17] = '{"win_again", 3'b111, 10'd100,  10'd200,  24'hFFFFFF};

        // Reset held low while clocking with a white pixel in the window.
        reset           = 1'b0;
        readValueMemory = 3'b111;
        posicionX       = '0;
        posicionY       = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hold", {red, green, blue}, 24'h000000);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_release_no_edge", {red, green, blue}, 24'h000000);
        @(posedge clock);
        #1;
        chk("reset_first_edge", {red, green, blue}, 24'hFFFFFF);

        // Table-driven vectors on the default instance.
        for (int unsigned i = 0; i < 18; i++) begin
            step(vecs[i].code, vecs[i].x, vecs[i].y);
            chk(vecs[i].name, {red, green, blue}, vecs[i].exp_rgb);
        end

        // Non-black background instance.
        step(3'b110, 10'd300, 10'd300);
        chk("bg_override", {red2, green2, blue2}, 24'h0000FF);
        chk("bg_default", {red, green, blue}, 24'h000000);
        step(3'b111, 10'd639, 10'd479);
        chk("bg_vis_edge", {red2, green2, blue2}, 24'h0000FF);
        step(3'b111, 10'd640, 10'd10);
        chk("bg_blank_wins", {red2, green2, blue2}, 24'h000000);
        step(3'b110, 10'd5, 10'd5);
        chk("bg_window", {red2, green2, blue2}, 24'hFFFF00);

        // Latency: outputs lag by one rising edge and never move on a falling edge.
        step(3'b111, 10'd20, 10'd20);
        chk("lat_prime", {red, green, blue}, 24'hFFFFFF);
        begin
            logic [2:0]  codes[4];
            logic [23:0] exps[4];
            logic [23:0] prev;
            codes = '{3'b001, 3'b010, 3'b100, 3'b000};
            exps  = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h000000};
            prev  = 24'hFFFFFF;
            for (int unsigned i = 0; i < 4; i++) begin
                readValueMemory = codes[i];
                #1;
                chk("lat_no_comb", {red, green, blue}, prev);
                @(negedge clock);
                #1;
                chk("lat_no_negedge", {red, green, blue}, prev);
                @(posedge clock);
                #1;
                chk("lat_one_edge", {red, green, blue}, exps[i]);
                prev = exps[i];
            end
        end

        // Mid-frame reset: immediate clear, normal output on first edge after release.
        step(3'b111, 10'd50, 10'd50);
        chk("mid_pre", {red, green, blue}, 24'hFFFFFF);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_clear", {red, green, blue}, 24'h000000);
        chk("mid_async_clear_bg", {red2, green2, blue2}, 24'h000000);
        @(posedge clock);
        #1;
        chk("mid_held", {red, green, blue}, 24'h000000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_resume", {red, green, blue}, 24'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/region_pantalla.md
Name: region_pantalla

Overview:
Pixel colour stage of the VGA output path. Each clock it takes the current beam position and the 3-bit colour code read from video memory for that position. It produces registered 8-bit red/green/blue drive values. Pixels inside a configurable image window show the memory colour; visible pixels outside the window show a background colour; pixels outside the visible area are forced black.

Parameters:
H_VISIBLE, 640, visible pixels per line; x >= H_VISIBLE is blanking.
V_VISIBLE, 480, visible lines per frame; y >= V_VISIBLE is blanking.
REGION_X0, 0, first column of the image window (inclusive).
REGION_Y0, 0, first row of the image window (inclusive).
REGION_W, 256, image window width in pixels.
REGION_H, 256, image window height in pixels.
BG_COLOR, 3'b000, 3-bit colour code for visible pixels outside the window.

Ports:
clock  input  1  pixel clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
readValueMemory  input  3  colour code from video memory for the current position; bit2 = R, bit1 = G, bit0 = B.
posicionX  input  10  current column, unsigned.
posicionY  input  10  current row, unsigned.
red  output  8  red intensity.
green  output  8  green intensity.
blue  output  8  blue intensity.

Behaviour:
- Reset: while reset = 0, red, green and blue = 8'h00 immediately (asynchronous). Outputs hold 0 until the first rising edge after reset deasserts.
- Sampling: readValueMemory, posicionX and posicionY are sampled on the same rising edge. The memory value belongs to the position presented in that same cycle; this block adds no alignment delay.
- Latency: exactly 1 clock. Outputs are registers, updated at the edge that samples the inputs. There is no combinational path from inputs to outputs.
- Classification, evaluated in this priority order:
  1. Blanking: posicionX >= H_VISIBLE or posicionY >= V_VISIBLE gives colour code 000.
  2. Window: REGION_X0 <= x < REGION_X0+REGION_W and REGION_Y0 <= y < REGION_Y0+REGION_H gives readValueMemory.
  3. Otherwise: BG_COLOR.
- Window bounds are computed in 11 bits so that X0+W or Y0+H up to 1024 cannot wrap. The window is clipped by the visible area; blanking always wins.
- Colour expansion: each code bit drives its whole channel to 8'hFF when 1 and 8'h00 when 0. Mapping:
  - 000 black, 001 blue, 010 green, 100 red
  - 011 cyan, 101 magenta, 110 yellow, 111 white
- X and Y, or values X or Z on readValueMemory: no requirement. X or Z on reset: no requirement.
- Reset mid-frame: outputs go to 0 at once. Normal operation resumes on the first rising edge after release, with no recovery cycles.
- No internal counters. Behaviour is a pure function of the inputs sampled on the previous edge.

Test Plan:
- Reset: hold reset = 0 while toggling clock with readValueMemory = 3'b111 and x = y = 0 -> red = green = blue = 8'h00. Release reset -> after the next edge all channels = 8'hFF.
- Colour sweep at y = 0, x = 0..7, codes 000, 001, 010, 100, 011, 101, 110, 111 (one per edge) -> one edge later RGB = (00,00,00), (00,00,FF), (00,FF,00), (FF,00,00), (00,FF,FF), (FF,00,FF), (FF,FF,00), (FF,FF,FF).
- Window boundary, defaults, readValueMemory = 3'b100:
  - x = 255, y = 0 -> red = FF, green = 00, blue = 00.
  - x = 256, y = 0 -> background: all channels 00.
  - Repeat with x = 0, y = 255 and x = 0, y = 256.
- Background override: BG_COLOR = 3'b001, x = 300, y = 300, readValueMemory = 3'b110 -> RGB = (00,00,FF).
- Blanking: readValueMemory = 3'b111.
  - x = 639, y = 479 -> background colour.
  - x = 640, y = 10 -> all channels 00.
  - x = 10, y = 480 -> all channels 00.
  - x = 1023, y = 1023 -> all channels 00.
- Latency check: change the code on every edge -> each output change lags its input by exactly one rising edge. Outputs must not change on falling edges.
